// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the burst UART transmitter:
//   - state_t     : transmitter FSM states
//   - BAUD_*      : supported baud rates, selected by a 2-bit speed code
//   - calc_div    : clock-frequency/speed-code -> clocks per bit (min 1)
//   - even_parity : XOR of a data byte (parity builds only)
//   - DATA_BITS / FRAME_BITS / BIT_W : frame shape and bit-position width
// Optional feature macro: UART_TX_PARITY_EN adds an even-parity bit.
// ----------------------------------------------------------------------------
package uart_pkg;

   localparam int unsigned BAUD_9600   = 32'd9600;
   localparam int unsigned BAUD_19200  = 32'd19200;
   localparam int unsigned BAUD_57600  = 32'd57600;
   localparam int unsigned BAUD_115200 = 32'd115200;

   // Divider width covers clock frequencies far above any practical system.
   localparam int DIV_W = 24;
   localparam logic [DIV_W-1:0] DIV_ONE = {{(DIV_W-1){1'b0}}, 1'b1};

   localparam int DATA_BITS = 8;
`ifdef UART_TX_PARITY_EN
   localparam int FRAME_BITS = 11;   // start + 8 data + parity + stop
`else
   localparam int FRAME_BITS = 10;   // start + 8 data + stop
`endif
   localparam int BIT_W = $clog2(FRAME_BITS);

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_START_BIT  = 3'd1,
      S_DATA_BITS  = 3'd2,
`ifdef UART_TX_PARITY_EN
      S_PARITY_BIT = 3'd3,
`endif
      S_STOP_BIT   = 3'd4
   } state_t;

   // Clocks per bit for a speed code; truncating divide, clamped to at least 1.
   function automatic logic [DIV_W-1:0] calc_div(input int unsigned clk_freq,
                                                  input logic [1:0]  speed);
      int unsigned baud;
      int unsigned div;
      case (speed)
         2'd0:    baud = BAUD_9600;
         2'd1:    baud = BAUD_19200;
         2'd2:    baud = BAUD_57600;
         default: baud = BAUD_115200;
      endcase
      div = clk_freq / baud;
      if (div == 32'd0) begin
         div = 32'd1;
      end else begin
         div = div;
      end
      return div[DIV_W-1:0];
   endfunction

`ifdef UART_TX_PARITY_EN
   // Even parity bit: makes the total count of ones (data + parity) even.
   function automatic logic even_parity(input logic [7:0] b);
      return ^b;
   endfunction
`endif

endpackage

// File: rtl/uart_baud_gen.sv
// ----------------------------------------------------------------------------
// uart_baud_gen
// Loadable down-counter producing a one-cycle bit tick every DIV clocks.
// A load strobe captures a new divider and restarts the count so that the
// first tick lands exactly DIV clocks after the load edge.
// Ports:
//   clk     : system clock
//   reset   : synchronous active-high reset
//   i_load  : restart strobe (frame start)
//   i_div   : clocks per bit, captured on i_load
//   o_tick  : high during the last clock of each bit period
// ----------------------------------------------------------------------------
module uart_baud_gen
   import uart_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             i_load,
   input  logic [DIV_W-1:0] i_div,
   output logic             o_tick
);

   logic [DIV_W-1:0] r_cnt;
   logic [DIV_W-1:0] r_div;

   // Count down from DIV-1 to 0, reloading on load strobe or on wrap.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt <= {DIV_W{1'b0}};
         r_div <= DIV_ONE;
      end else if (i_load) begin
         r_div <= i_div;
         r_cnt <= i_div - DIV_ONE;
      end else if (r_cnt == {DIV_W{1'b0}}) begin
         r_cnt <= r_div - DIV_ONE;
      end else begin
         r_cnt <= r_cnt - DIV_ONE;
      end
   end

   assign o_tick = (r_cnt == {DIV_W{1'b0}});

endmodule

// File: rtl/uart_burst_tx.sv
// ----------------------------------------------------------------------------
// uart_burst_tx
// On a start pulse, captures a byte, a speed code and a byte-count code and
// sends num_bytes+1 back-to-back UART frames (data, data+1, ...) on tx.
// Optional feature macro: UART_TX_PARITY_EN (even parity bit, 11-bit frame).
// Parameters:
//   CLK_FREQ  : system clock in Hz, used to derive the bit period
// Ports:
//   clk       : system clock
//   reset     : synchronous active-high reset
//   start     : one-cycle request, honoured only when idle
//   data      : first payload byte
//   speed     : 0=9600, 1=19200, 2=57600, 3=115200 baud
//   num_bytes : burst length minus one
//   tx        : UART line, idle high (registered)
//   busy      : burst in progress (registered)
//   done      : one-cycle pulse as the burst ends (registered)
// ----------------------------------------------------------------------------
module uart_burst_tx
   import uart_pkg::*;
#(
   parameter int unsigned CLK_FREQ = 100_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] data,
   input  logic [1:0] speed,
   input  logic [1:0] num_bytes,
   output logic       tx,
   output logic       busy,
   output logic       done
);

   state_t           r_state, w_next;
   logic [7:0]       r_data, r_cur, w_cur_next, r_shift, w_shift_next;
   logic [1:0]       r_speed, r_nb, r_k, w_k_next, w_k_inc;
   logic [BIT_W-1:0] r_bit, w_bit_next;
   logic             w_cap, w_load, w_tick, w_done_next;
   logic             w_tx_next, w_busy_next;
   logic             r_tx, r_busy, r_done;
   logic [DIV_W-1:0] w_div;

   // In IDLE the divider comes from the live input (it is loaded on the
   // capture edge); during a burst only the captured speed is used.
   assign w_div   = calc_div(CLK_FREQ, (r_state == S_IDLE) ? speed : r_speed);
   assign w_k_inc = r_k + 2'd1;

   uart_baud_gen u_baud (
      .clk    (clk),
      .reset  (reset),
      .i_load (w_load),
      .i_div  (w_div),
      .o_tick (w_tick)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state and datapath next values; r_bit is the position in the frame.
   always_comb begin
      w_next       = r_state;
      w_cap        = 1'b0;
      w_load       = 1'b0;
      w_k_next     = r_k;
      w_cur_next   = r_cur;
      w_shift_next = r_shift;
      w_bit_next   = r_bit;
      w_done_next  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_next       = S_START_BIT;
               w_cap        = 1'b1;
               w_load       = 1'b1;
               w_k_next     = 2'd0;
               w_cur_next   = data;
               w_shift_next = data;
               w_bit_next   = {BIT_W{1'b0}};
            end else begin
               w_next = S_IDLE;
            end
         end
         S_START_BIT: begin
            if (w_tick) begin
               w_next     = S_DATA_BITS;
               w_bit_next = r_bit + 1'b1;
            end else begin
               w_next = S_START_BIT;
            end
         end
         S_DATA_BITS: begin
            if (w_tick) begin
               w_bit_next   = r_bit + 1'b1;
               w_shift_next = {1'b0, r_shift[7:1]};
               // Data occupies frame positions 1..DATA_BITS.
               if (r_bit == BIT_W'(DATA_BITS)) begin
`ifdef UART_TX_PARITY_EN
                  w_next = S_PARITY_BIT;
`else
                  w_next = S_STOP_BIT;
`endif
               end else begin
                  w_next = S_DATA_BITS;
               end
            end else begin
               w_next = S_DATA_BITS;
            end
         end
`ifdef UART_TX_PARITY_EN
         S_PARITY_BIT: begin
            if (w_tick) begin
               w_next     = S_STOP_BIT;
               w_bit_next = r_bit + 1'b1;
            end else begin
               w_next = S_PARITY_BIT;
            end
         end
`endif
         S_STOP_BIT: begin
            if (w_tick) begin
               w_bit_next = {BIT_W{1'b0}};
               if (r_k < r_nb) begin
                  // Next byte starts with no idle gap; restart the bit timer.
                  w_next       = S_START_BIT;
                  w_load       = 1'b1;
                  w_k_next     = w_k_inc;
                  w_cur_next   = r_data + {6'd0, w_k_inc};
                  w_shift_next = r_data + {6'd0, w_k_inc};
               end else begin
                  w_next      = S_IDLE;
                  w_done_next = 1'b1;
               end
            end else begin
               w_next = S_STOP_BIT;
            end
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   // Output decode from the next state so tx/busy can be registered.
   always_comb begin
      w_tx_next   = 1'b1;
      w_busy_next = (w_next != S_IDLE);
      case (w_next)
         S_START_BIT:  w_tx_next = 1'b0;
         S_DATA_BITS:  w_tx_next = w_shift_next[0];
`ifdef UART_TX_PARITY_EN
         S_PARITY_BIT: w_tx_next = even_parity(w_cur_next);
`endif
         default:      w_tx_next = 1'b1;
      endcase
   end

   // Datapath, captured settings and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_data  <= 8'd0;
         r_speed <= 2'd0;
         r_nb    <= 2'd0;
         r_k     <= 2'd0;
         r_cur   <= 8'd0;
         r_shift <= 8'd0;
         r_bit   <= {BIT_W{1'b0}};
         r_tx    <= 1'b1;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         if (w_cap) begin
            r_data  <= data;
            r_speed <= speed;
            r_nb    <= num_bytes;
         end
         r_k     <= w_k_next;
         r_cur   <= w_cur_next;
         r_shift <= w_shift_next;
         r_bit   <= w_bit_next;
         r_tx    <= w_tx_next;
         r_busy  <= w_busy_next;
         r_done  <= w_done_next;
      end
   end

   assign tx   = r_tx;
   assign busy = r_busy;
   assign done = r_done;

endmodule

// File: tb/tb_uart_burst_tx.sv
module tb_uart_burst_tx;

   localparam int unsigned CLK_FREQ = 1_152_000;
`ifdef UART_TX_PARITY_EN
   localparam int FRAME = 11;
`else
   localparam int FRAME = 10;
`endif

   logic       clk = 1'b0;
   logic       reset, start;
   logic [7:0] data;
   logic [1:0] speed, num_bytes;
   logic       tx, busy, done;

   uart_burst_tx #(.CLK_FREQ(CLK_FREQ)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .data      (data),
      .speed     (speed),
      .num_bytes (num_bytes),
      .tx        (tx),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] b;
      int         div;
      bit         last;
   } exp_t;

   exp_t exp_q[$];
   int   vectors = 0;
   int   miscompares = 0;
   bit   mon_en = 1'b0;
   bit   flush = 1'b0;

   // Reference bit period: clock / baud, at least one clock.
   function automatic int ref_div(input logic [1:0] sp);
      int baud;
      int d;
      case (sp)
         2'd0:    baud = 9600;
         2'd1:    baud = 19200;
         2'd2:    baud = 57600;
         default: baud = 115200;
      endcase
      d = int'(CLK_FREQ) / baud;
      if (d < 1) d = 1;
      return d;
   endfunction

   // Reference line level at frame position pos for byte b.
   function automatic logic ref_bit(input logic [7:0] b, input int pos);
      int ones;
      if (pos == 0) return 1'b0;
      if (pos <= 8) return b[pos-1];
      if (FRAME == 11 && pos == 9) begin
         ones = 0;
         for (int i = 0; i < 8; i++) ones += int'(b[i]);
         return (ones % 2 == 1) ? 1'b1 : 1'b0;
      end
      return 1'b1;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Monitor: a receiver that pops the expected byte when a start bit appears
   // and requires every bit to hold its value for exactly the expected period.
   exp_t cur;
   bit   mon_active = 1'b0, pending_done = 1'b0, seamless = 1'b0, lost = 1'b0;
   bit   bit_bad = 1'b0;
   int   bit_idx = 0, cyc = 0;
   logic bad_tx, bad_busy;

   always @(negedge clk) begin
      if (mon_en) begin
         if (flush) begin
            flush = 1'b0;
            exp_q.delete();
            mon_active = 1'b0; pending_done = 1'b0; seamless = 1'b0; lost = 1'b0;
            chk("reset_tx", 32'(tx), 32'd1);
            chk("reset_busy", 32'(busy), 32'd0);
            chk("reset_done", 32'(done), 32'd0);
         end else if (pending_done) begin
            pending_done = 1'b0;
            chk("done_pulse_done_busy_tx", 32'({done, busy, tx}), 32'b101);
         end else begin
            if (!mon_active) begin
               chk("idle_done", 32'(done), 32'd0);
               if (seamless) chk("no_gap_start", 32'(tx), 32'd0);
               seamless = 1'b0;
               if (lost) begin
                  if (tx === 1'b1 && busy === 1'b0) lost = 1'b0;
               end else if (tx === 1'b0) begin
                  if (exp_q.size() == 0) begin
                     vectors++;
                     miscompares++;
                     $display("FAIL unexpected_frame: got start bit, required idle line (t=%0t)", $time);
                     lost = 1'b1;
                  end else begin
                     cur = exp_q.pop_front();
                     mon_active = 1'b1; bit_idx = 0; cyc = 0; bit_bad = 1'b0;
                  end
               end
            end
            if (mon_active) begin
               if (tx !== ref_bit(cur.b, bit_idx) || busy !== 1'b1 || done !== 1'b0) begin
                  bit_bad = 1'b1; bad_tx = tx; bad_busy = busy;
               end
               cyc++;
               if (cyc == cur.div) begin
                  vectors++;
                  if (bit_bad) begin
                     miscompares++;
                     $display("FAIL frame_bit: byte %02h pos %0d got tx=%b busy=%b, required tx=%b busy=1 for %0d clocks",
                              cur.b, bit_idx, bad_tx, bad_busy, ref_bit(cur.b, bit_idx), cur.div);
                  end
                  bit_bad = 1'b0; cyc = 0; bit_idx++;
                  if (bit_idx == FRAME) begin
                     mon_active = 1'b0;
                     if (cur.last) pending_done = 1'b1;
                     else          seamless = 1'b1;
                  end
               end
            end
         end
      end
   end

   // Issue a burst: push expected bytes, pulse start, scramble inputs afterwards.
   task automatic issue(input logic [7:0] d, input logic [1:0] sp, input logic [1:0] nb);
      exp_t e;
      start = 1'b1; data = d; speed = sp; num_bytes = nb;
      for (int k = 0; k <= int'(nb); k++) begin
         e.b = d + 8'(k); e.div = ref_div(sp); e.last = (k == int'(nb));
         exp_q.push_back(e);
      end
      @(posedge clk); #1;
      start = 1'b0;
      data = 8'($urandom); speed = 2'($urandom); num_bytes = 2'($urandom);
      @(negedge clk);
      chk("start_latency_tx_busy", 32'({tx, busy}), 32'b01);
   endtask

   task automatic wait_done(input int budget);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(negedge clk);
         if (done === 1'b1) seen = 1'b1;
      end
      chk("done_within_budget", 32'(seen), 32'd1);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; data = 8'd0; speed = 2'd0; num_bytes = 2'd0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("init_tx", 32'(tx), 32'd1);
      chk("init_busy", 32'(busy), 32'd0);
      chk("init_done", 32'(done), 32'd0);
      mon_en = 1'b1;

      // Single byte, fastest speed.
      issue(8'hA5, 2'd3, 2'd0);
      wait_done(200);
      repeat (5) @(negedge clk);

      // Four-byte burst with wrap through 00.
      issue(8'hFE, 2'd3, 2'd3);
      wait_done(500);
      repeat (5) @(negedge clk);

      // Slowest speed.
      issue(8'h1A, 2'd0, 2'd0);
      wait_done(1400);
      repeat (5) @(negedge clk);

      // Start pulse mid-burst must be ignored.
      issue(8'h5C, 2'd3, 2'd1);
      repeat (150) @(negedge clk);
      @(posedge clk); #1;
      start = 1'b1; data = 8'h33; speed = 2'd0; num_bytes = 2'd3;
      @(posedge clk); #1;
      start = 1'b0; data = 8'h99; speed = 2'd1;
      wait_done(200);
      repeat (300) @(negedge clk);

      // Back-to-back: start issued in the done cycle.
      issue(8'($urandom), 2'd3, 2'd1);
      wait_done(300);
      issue(8'($urandom), 2'd2, 2'd0);
      wait_done(400);
      repeat (5) @(negedge clk);

      // Reset during the data bits of byte 2 of a 4-byte burst.
      issue(8'($urandom), 2'd3, 2'd3);
      repeat (130) @(negedge clk);
      @(posedge clk); #1 reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0; flush = 1'b1;
      repeat (600) @(negedge clk);
      issue(8'h3C, 2'd3, 2'd2);
      wait_done(400);
      repeat (5) @(negedge clk);

`ifdef UART_TX_PARITY_EN
      issue(8'h07, 2'd3, 2'd0);
      wait_done(200);
      repeat (5) @(negedge clk);
`endif

      // Randomized bursts.
      for (int n = 0; n < 6; n++) begin
         issue(8'($urandom), 2'($urandom_range(3, 1)), 2'($urandom));
         wait_done(4 * 11 * 60 + 50);
         repeat ($urandom_range(3, 0)) @(negedge clk);
      end

      repeat (20) @(negedge clk);
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      chk("monitor_idle", 32'(mon_active), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
